// File: rtl/ddr3_seq_pkg.sv
// Shared definitions for the DDR3 command sequencer: command word field
// positions, sequencer state encoding and the idle (NOP) command word.
package ddr3_seq_pkg;

    localparam int CMD_END_BIT   = 35;
    localparam int CMD_PAUSE_BIT = 34;
    localparam int CMD_PCNT_MSB  = 29;
    localparam int CMD_PCNT_LSB  = 20;

    localparam logic [35:0] CMD_NOP = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/cmd_sequencer_if.sv
// Bundle of run-control and command-memory signals around the sequencer.
// The slave modport is the sequencer; master is the controller/memory side.
interface cmd_sequencer_if #(
    parameter int CMD_WIDTH  = 36,
    parameter int ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] run_addr;
    logic [3:0]            run_chn;
    logic                  run_seq;
    logic                  run_busy;
    logic                  run_done;
    logic [3:0]            seq_chn;
    logic                  cmd_re;
    logic [ADDR_WIDTH-1:0] cmd_raddr;
    logic [CMD_WIDTH-1:0]  cmd_rdata;
    logic [CMD_WIDTH-1:0]  phy_cmd;

    modport master (
        output run_addr, run_chn, run_seq, cmd_rdata,
        input  run_busy, run_done, seq_chn, cmd_re, cmd_raddr, phy_cmd
    );

    modport slave (
        input  run_addr, run_chn, run_seq, cmd_rdata,
        output run_busy, run_done, seq_chn, cmd_re, cmd_raddr, phy_cmd
    );
endinterface

// File: rtl/cmd_sequencer.sv
// Plays a command sequence out of command memory onto phy_cmd, honouring
// per-word pause counts and stopping after the END word.
import ddr3_seq_pkg::*;

module cmd_sequencer #(
    parameter int CMD_WIDTH   = 36,
    parameter int ADDR_WIDTH  = 11,
    parameter int PAUSE_WIDTH = 10
) (
    input  logic            mclk,
    input  logic            rst_n,
    cmd_sequencer_if.slave  bus
);

    seq_state_t             state_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic                   re_reg;
    logic [CMD_WIDTH-1:0]   phy_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [3:0]             chn_reg;
    logic [PAUSE_WIDTH-1:0] pause_cnt_reg;
    logic                   end_seen_reg;

    logic                   word_end;
    logic                   word_pause;
    logic [PAUSE_WIDTH-1:0] word_cnt;
    logic [CMD_WIDTH-1:0]   phy_word;
    logic                   stop_read;

    assign word_end   = bus.cmd_rdata[CMD_END_BIT];
    assign word_pause = bus.cmd_rdata[CMD_PAUSE_BIT];
    assign word_cnt   = PAUSE_WIDTH'(bus.cmd_rdata[CMD_PCNT_MSB:CMD_PCNT_LSB]);

    always_comb begin
        phy_word                = bus.cmd_rdata;
        phy_word[CMD_END_BIT]   = 1'b0;
        phy_word[CMD_PAUSE_BIT] = 1'b0;
    end

    // The read issued in the cycle an END word arrives is suppressed so the
    // address bus never walks past the last word of the sequence.
    assign stop_read     = (state_reg == S_RUN) && word_end;
    assign bus.cmd_re    = re_reg && !stop_read;
    assign bus.cmd_raddr = stop_read ? addr_reg - ADDR_WIDTH'(1) : addr_reg;

    assign bus.phy_cmd  = phy_reg;
    assign bus.run_busy = busy_reg;
    assign bus.run_done = done_reg;
    assign bus.seq_chn  = chn_reg;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            re_reg        <= 1'b0;
            phy_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            chn_reg       <= '0;
            pause_cnt_reg <= '0;
            end_seen_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.run_seq) begin
                        addr_reg  <= bus.run_addr;
                        chn_reg   <= bus.run_chn;
                        busy_reg  <= 1'b1;
                        re_reg    <= 1'b1;
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    addr_reg  <= addr_reg + ADDR_WIDTH'(1);
                    state_reg <= S_RUN;
                end
                S_RUN: begin
                    phy_reg <= phy_word;
                    // END words pass through HOLD too (count 0 when not paused),
                    // giving them their one output cycle before DONE.
                    if (word_end || word_pause) begin
                        re_reg        <= 1'b0;
                        end_seen_reg  <= word_end;
                        pause_cnt_reg <= word_pause ? word_cnt : '0;
                        state_reg     <= S_HOLD;
                        if (word_end) begin
                            addr_reg <= addr_reg - ADDR_WIDTH'(1);
                        end
                    end else begin
                        addr_reg <= addr_reg + ADDR_WIDTH'(1);
                    end
                end
                S_HOLD: begin
                    if (pause_cnt_reg == '0) begin
                        phy_reg <= CMD_WIDTH'(CMD_NOP);
                        if (end_seen_reg) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            // addr_reg still holds the word after the paused
                            // one; refetch it since its speculative read was dropped.
                            re_reg    <= 1'b1;
                            state_reg <= S_FETCH;
                        end
                    end else begin
                        pause_cnt_reg <= pause_cnt_reg - PAUSE_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    end_seen_reg <= 1'b0;
                    state_reg    <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: a per-cycle scoreboard of
// phy_cmd/run_busy/run_done plus per-scenario checks on reads and channel.
`timescale 1ns/1ps
module tb_cmd_sequencer;
    import ddr3_seq_pkg::*;

    localparam int CW = 36;
    localparam int AW = 11;
    localparam int PW = 10;
    localparam logic [CW-1:0] POISON = 36'h0_5A5A_C3C3;

    typedef struct {
        logic [CW-1:0] phy;
        logic          busy;
        logic          done;
    } exp_t;

    logic mclk  = 1'b0;
    logic rst_n = 1'b0;

    cmd_sequencer_if #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

    cmd_sequencer #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW), .PAUSE_WIDTH(PW)) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 mclk = ~mclk;

    logic [CW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_log[$];
    logic [CW-1:0] seq_words[$];
    exp_t          exp_q[$];
    logic [AW-1:0] max_raddr;
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    // Command memory: registered read, data one cycle after cmd_re.
    always @(posedge mclk) begin
        cyc <= cyc + 1;
        if (bus.cmd_re) begin
            bus.cmd_rdata <= mem[bus.cmd_raddr];
            rd_log.push_back(bus.cmd_raddr);
        end
    end

    // Scoreboard: one expected entry per cycle, compared mid-cycle.
    always @(negedge mclk) begin
        exp_t e;
        if (bus.cmd_raddr > max_raddr) max_raddr = bus.cmd_raddr;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.phy_cmd !== e.phy) begin
                errors++;
                $display("FAIL phy_cmd cyc %0d got %h want %h", cyc, bus.phy_cmd, e.phy);
            end
            checks++;
            if (bus.run_busy !== e.busy) begin
                errors++;
                $display("FAIL run_busy cyc %0d got %b want %b", cyc, bus.run_busy, e.busy);
            end
            checks++;
            if (bus.run_done !== e.done) begin
                errors++;
                $display("FAIL run_done cyc %0d got %b want %b", cyc, bus.run_done, e.done);
            end
        end
    end

    function automatic exp_t mk_exp(input logic [CW-1:0] p, input logic b, input logic d);
        exp_t e;
        e.phy  = p;
        e.busy = b;
        e.done = d;
        return e;
    endfunction

    function automatic logic [CW-1:0] mk_word(input logic is_end, input logic is_pause, input int n);
        logic [63:0]   r;
        logic [CW-1:0] w;
        r = {$urandom(), $urandom()};
        w = r[CW-1:0];
        w[CMD_END_BIT]   = is_end;
        w[CMD_PAUSE_BIT] = is_pause;
        if (is_pause) w[CMD_PCNT_MSB:CMD_PCNT_LSB] = PW'(n);
        return w;
    endfunction

    function automatic int bad_reads(input logic [AW-1:0] a, input int n);
        logic [AW-1:0] off;
        int bad = 0;
        foreach (rd_log[i]) begin
            off = rd_log[i] - a;
            if (int'(off) >= n) bad++;
        end
        return bad;
    endfunction

    // Loads seq_words at address a, pulses run_seq and queues the expected
    // per-cycle trace (keep>0 truncates it for aborted runs).
    task automatic start_seq(input logic [AW-1:0] a, input logic [3:0] ch, input int keep);
        logic [CW-1:0] w;
        logic [CW-1:0] c;
        foreach (seq_words[i]) mem[AW'(a + AW'(i))] = seq_words[i];
        @(posedge mclk); #1;
        rd_log.delete();
        bus.run_addr = a;
        bus.run_chn  = ch;
        bus.run_seq  = 1'b1;
        $display("seq start addr=%h chn=%h words=%0d", a, ch, seq_words.size());
        exp_q.push_back(mk_exp('0, 1'b0, 1'b0));
        repeat (2) exp_q.push_back(mk_exp('0, 1'b1, 1'b0));
        foreach (seq_words[i]) begin
            w = seq_words[i];
            c = w;
            c[CMD_END_BIT]   = 1'b0;
            c[CMD_PAUSE_BIT] = 1'b0;
            if (w[CMD_PAUSE_BIT]) begin
                for (int k = 0; k <= int'(w[CMD_PCNT_MSB:CMD_PCNT_LSB]); k++)
                    exp_q.push_back(mk_exp(c, 1'b1, 1'b0));
                if (!w[CMD_END_BIT]) repeat (2) exp_q.push_back(mk_exp('0, 1'b1, 1'b0));
            end else begin
                exp_q.push_back(mk_exp(c, 1'b1, 1'b0));
            end
            if (w[CMD_END_BIT]) break;
        end
        exp_q.push_back(mk_exp('0, 1'b0, 1'b1));
        exp_q.push_back(mk_exp('0, 1'b0, 1'b0));
        if (keep > 0) while (exp_q.size() > keep) void'(exp_q.pop_back());
        @(posedge mclk); #1;
        bus.run_seq = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge mclk);
        end
        ok = (exp_q.size() == 0);
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        checks++; if (bus.phy_cmd !== '0) begin errors++; $display("FAIL reset_phy got %h want 0", bus.phy_cmd); end
        checks++; if (bus.run_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.run_busy); end
        checks++; if (bus.run_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.run_done); end
        checks++; if (bus.cmd_re !== 1'b0) begin errors++; $display("FAIL reset_re got %b want 0", bus.cmd_re); end
        checks++; if (bus.cmd_raddr !== '0) begin errors++; $display("FAIL reset_raddr got %h want 0", bus.cmd_raddr); end
        checks++; if (bus.seq_chn !== 4'h0) begin errors++; $display("FAIL reset_chn got %h want 0", bus.seq_chn); end
        @(posedge mclk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        seq_words = '{mk_word(0, 0, 0), mk_word(0, 0, 0), mk_word(1, 0, 0)};
        max_raddr = '0;
        start_seq(11'h010, 4'h3, 0);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got pending want drained"); end
        checks++; if (max_raddr !== 11'h012) begin errors++; $display("FAIL basic_max_raddr got %h want 012", max_raddr); end
        checks++; if (bad_reads(11'h010, 3) !== 0) begin errors++; $display("FAIL basic_reads got %0d bad want 0", bad_reads(11'h010, 3)); end
        checks++; if (bus.seq_chn !== 4'h3) begin errors++; $display("FAIL basic_chn got %h want 3", bus.seq_chn); end
    endtask

    task automatic test_pause();
        bit ok;
        seq_words = '{mk_word(0, 0, 0), mk_word(0, 1, 3), mk_word(1, 0, 0)};
        start_seq(11'h040, 4'h6, 0);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL pause_timeout got pending want drained"); end
        checks++; if (bad_reads(11'h040, 3) !== 0) begin errors++; $display("FAIL pause_reads got %0d bad want 0", bad_reads(11'h040, 3)); end
        checks++; if (rd_log.size() == 0 || rd_log[0] !== 11'h040) begin errors++; $display("FAIL pause_first_read got %0d reads want first 040", rd_log.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [AW-1:0] want [3];
        want = '{11'h7FE, 11'h7FF, 11'h000};
        seq_words = '{mk_word(0, 0, 0), mk_word(0, 0, 0), mk_word(1, 0, 0)};
        start_seq(11'h7FE, 4'h1, 0);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got pending want drained"); end
        checks++; if (rd_log.size() !== 3) begin errors++; $display("FAIL wrap_nreads got %0d want 3", rd_log.size()); end
        for (int i = 0; i < 3 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== want[i]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, rd_log[i], want[i]); end
        end
    endtask

    task automatic test_ignore();
        bit ok;
        seq_words = '{mk_word(0, 0, 0), mk_word(0, 0, 0), mk_word(0, 0, 0), mk_word(1, 0, 0)};
        start_seq(11'h100, 4'h5, 0);
        @(posedge mclk); #1;
        bus.run_addr = 11'h200;
        bus.run_chn  = 4'hA;
        bus.run_seq  = 1'b1;
        @(posedge mclk); #1;
        bus.run_seq = 1'b0;
        checks++; if (bus.seq_chn !== 4'h5) begin errors++; $display("FAIL ignore_chn_mid got %h want 5", bus.seq_chn); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout got pending want drained"); end
        checks++; if (bus.seq_chn !== 4'h5) begin errors++; $display("FAIL ignore_chn_end got %h want 5", bus.seq_chn); end
        checks++; if (bad_reads(11'h100, 4) !== 0) begin errors++; $display("FAIL ignore_reads got %0d bad want 0", bad_reads(11'h100, 4)); end
    endtask

    task automatic test_reset_hold();
        bit ok;
        seq_words = '{mk_word(0, 0, 0), mk_word(0, 1, 5), mk_word(1, 0, 0)};
        start_seq(11'h300, 4'h7, 6);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rsthold_timeout got pending want drained"); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.phy_cmd !== '0) begin errors++; $display("FAIL rsthold_phy got %h want 0", bus.phy_cmd); end
        checks++; if (bus.run_busy !== 1'b0) begin errors++; $display("FAIL rsthold_busy got %b want 0", bus.run_busy); end
        checks++; if (bus.cmd_re !== 1'b0) begin errors++; $display("FAIL rsthold_re got %b want 0", bus.cmd_re); end
        checks++; if (bus.cmd_raddr !== '0) begin errors++; $display("FAIL rsthold_raddr got %h want 0", bus.cmd_raddr); end
        checks++; if (bus.seq_chn !== 4'h0) begin errors++; $display("FAIL rsthold_chn got %h want 0", bus.seq_chn); end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin @(posedge mclk); #1; rst_n = 1'b1; end
            @(negedge mclk);
            checks++;
            if (bus.run_done !== 1'b0 || bus.run_busy !== 1'b0) begin
                errors++;
                $display("FAIL rsthold_nodone got done=%b busy=%b want 0 0", bus.run_done, bus.run_busy);
            end
        end
        seq_words = '{mk_word(0, 0, 0), mk_word(1, 0, 0)};
        start_seq(11'h020, 4'h9, 0);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rsthold_restart got pending want drained"); end
        checks++; if (bus.seq_chn !== 4'h9) begin errors++; $display("FAIL rsthold_newchn got %h want 9", bus.seq_chn); end
    endtask

    task automatic test_end_pause();
        bit ok;
        seq_words = '{mk_word(1, 1, 0)};
        start_seq(11'h400, 4'h2, 0);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL endpause_timeout got pending want drained"); end
        checks++; if (rd_log.size() !== 1) begin errors++; $display("FAIL endpause_nreads got %0d want 1", rd_log.size()); end
    endtask

    initial begin
        bus.run_addr = '0;
        bus.run_chn  = '0;
        bus.run_seq  = 1'b0;
        max_raddr    = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = POISON;
        test_reset();
        test_basic();
        test_pause();
        test_wrap();
        test_ignore();
        test_reset_hold();
        test_end_pause();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 36, meaning the width of command memory words and phy_cmd.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, meaning the width of the command memory address.
REQ-003 SHALL have parameter PAUSE_WIDTH, default 10, meaning the width of the pause count field.
REQ-004 mclk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 run_addr  input  ADDR_WIDTH  sequence start address.
REQ-007 run_chn  input  4  data channel for this sequence.
REQ-008 run_seq  input  1  one-cycle start request.
REQ-009 run_busy  output  1  sequence in progress.
REQ-010 run_done  output  1  one-cycle pulse when a sequence finishes.
REQ-011 seq_chn  output  4  run_chn latched at start.
REQ-012 cmd_re  output  1  command memory read enable.
REQ-013 cmd_raddr  output  ADDR_WIDTH  command memory read address.
REQ-014 cmd_rdata  input  CMD_WIDTH  command memory data, valid one cycle after cmd_re.
REQ-015 phy_cmd  output  CMD_WIDTH  registered command word to the PHY command stage.

Function
REQ-016 Word fields SHALL be: bit 35 END, bit 34 PAUSE, bits 29:20 pause count N; phy_cmd SHALL carry the word with bits 35:34 cleared.
REQ-017 States SHALL be IDLE, FETCH, RUN, HOLD and DONE.
REQ-018 In IDLE, run_seq SHALL latch run_addr and run_chn, set run_busy and go to FETCH.
REQ-019 run_seq while run_busy=1 SHALL be ignored.
REQ-020 In FETCH, cmd_re SHALL be 1 with cmd_raddr equal to the start address, and the block SHALL go to RUN next cycle.
REQ-021 In RUN, cmd_re SHALL be 1 every cycle, addressing consecutive words.
REQ-022 In RUN, cmd_rdata SHALL register into phy_cmd each cycle.
REQ-023 Latency: the first word SHALL appear on phy_cmd 3 cycles after the cycle in which run_seq is sampled.
REQ-024 A word with PAUSE=1 SHALL be held on phy_cmd for N+1 cycles in total (state HOLD); N=0 SHALL give a single cycle.
REQ-025 During HOLD, the speculatively read next word SHALL be discarded.
REQ-026 On leaving HOLD, the next word SHALL be re-read, so that no command word is skipped or duplicated.
REQ-027 Output SHALL be contiguous in RUN, and there SHALL be exactly 2 bubble cycles (phy_cmd=0) after each HOLD.
REQ-028 A word with END=1 SHALL be output, including its pause if PAUSE=1, and SHALL then be followed by state DONE.
REQ-029 In DONE, phy_cmd SHALL be 0, run_done SHALL be 1 for exactly one cycle, and run_busy SHALL drop in the same cycle; the next state SHALL be IDLE.
REQ-030 cmd_raddr SHALL wrap from all-ones to 0.
REQ-031 No reads SHALL be issued after an END word is received.
REQ-032 phy_cmd SHALL be 0 in IDLE, FETCH and DONE.

Reset
REQ-033 On rst_n=0, asynchronously: state IDLE; phy_cmd=0, run_busy=0, run_done=0, cmd_re=0, cmd_raddr=0, seq_chn=0, pause counter=0.
REQ-034 Reset mid-sequence SHALL abort the sequence with no run_done pulse.
REQ-035 After rst_n deasserts, the first run_seq SHALL be accepted normally.

Structure
REQ-036 The package ddr3_seq_pkg SHALL hold the field bit positions (END, PAUSE, pause count), the state encoding and the NOP constant 0.
REQ-037 The block SHALL be a single module with no sub-modules; the pause counter SHALL be inline.

Verification
REQ-038 Start at address 0x010 with words A, B, C(END) -> phy_cmd shows A, B, C on cycles 3–5; run_done at cycle 6; cmd_raddr never exceeds 0x012.
REQ-039 Word B has PAUSE=1, N=3 -> B is held for 4 cycles; 2 zero cycles follow; then C; no word is lost.
REQ-040 Start at 0x7FE with 3 words -> addresses 0x7FE, 0x7FF, 0x000 are read.
REQ-041 run_seq is asserted again at cycle 2 of a busy sequence -> it is ignored; seq_chn keeps its first value (e.g. 4'h5).
REQ-042 rst_n is pulled low during HOLD -> all outputs go to 0 immediately; no run_done; a new run_seq then works.
REQ-043 The first word has both END and PAUSE set, N=0 -> a single phy_cmd cycle, then run_done.
